ahb_slave_interface: RTL and testbench
======================================

AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL expose these ports (clock and reset first):
- Hclk  in  1  bridge clock; all state updates on its rising edge
- Hreset  in  1  synchronous reset, active-high
- Hwrite  in  1  AHB write (1) / read (0)
- Hreadyin  in  1  AHB HREADY from the bus
- Htrans  in  2  AHB transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data
- Prdata  in  32  APB read data
- valid  out  1  qualified in-range transfer, to the APB FSM controller
- Haddr1, Haddr2  out  32 each  address pipeline stages 1 and 2
- Hwdata1, Hwdata2  out  32 each  write-data pipeline stages 1 and 2
- Hwritereg  out  1  registered Hwrite
- tempselx  out  3  one-hot peripheral select
- Hrdata  out  32  read data returned to AHB
- Hresp  out  2  AHB response: OKAY=00, ERROR=01
- Hreadyerr  out  1  error-path HREADY; the top level ANDs it with the FSM Hreadyout

Function
REQ-003 Address map:
- 0x8000_0000..0x83FF_FFFF -> tempselx=001
- 0x8400_0000..0x87FF_FFFF -> tempselx=010
- 0x8800_0000..0x8BFF_FFFF -> tempselx=100
- any other address -> tempselx=000
REQ-004 tempselx SHALL be combinational from Haddr.
REQ-005 valid SHALL be combinational, and SHALL be 1 only when all of these hold: Hreadyin=1, Htrans is NONSEQ or SEQ, tempselx!=000, and the error FSM is not in ERR_FIRST.
REQ-006 When Hreadyin=1, SHALL capture on each clock: Haddr1<=Haddr, Haddr2<=Haddr1, Hwritereg<=Hwrite. When Hreadyin=0, these SHALL hold their values.
REQ-007 Hwdata1<=Hwdata and Hwdata2<=Hwdata1 SHALL update every clock, unconditionally, so that data-phase data aligns one cycle after its address.
REQ-008 Hrdata SHALL equal Prdata combinationally, with zero latency.
REQ-009 Error FSM SHALL have states ERR_IDLE, ERR_FIRST and ERR_SECOND.
REQ-010 ERR_IDLE -> ERR_FIRST when Hreadyin=1, Htrans is NONSEQ or SEQ, and tempselx=000; otherwise the FSM SHALL stay in ERR_IDLE.
REQ-011 ERR_FIRST -> ERR_SECOND unconditionally; outputs in ERR_FIRST SHALL be Hresp=01 and Hreadyerr=0.
REQ-012 ERR_SECOND -> ERR_IDLE unconditionally; outputs in ERR_SECOND SHALL be Hresp=01 and Hreadyerr=1.
REQ-013 In ERR_IDLE, outputs SHALL be Hresp=00 and Hreadyerr=1.
REQ-014 An out-of-range address arriving during ERR_SECOND SHALL re-enter ERR_FIRST on the next cycle, i.e. back-to-back errors.
REQ-015 An in-range transfer during ERR_SECOND SHALL assert valid normally.
REQ-016 Htrans=BUSY or IDLE SHALL never assert valid and SHALL never start an error sequence.

Reset
REQ-017 While Hreset=1 at a rising edge: Haddr1, Haddr2, Hwdata1, Hwdata2 SHALL become 0, Hwritereg SHALL become 0, and the FSM SHALL go to ERR_IDLE.
REQ-018 Reset asserted mid error sequence SHALL abort it; Hresp=00 and Hreadyerr=1 SHALL hold from the cycle after reset.
REQ-019 Combinational outputs (valid, tempselx, Hrdata) SHALL follow their inputs even during reset. valid SHALL still be gated by REQ-005.

Configuration
REQ-020 Macro AHB_ERR_RESP_EN: when defined, the error FSM and REQ-009..REQ-014 and REQ-018 SHALL be compiled in.
REQ-021 When AHB_ERR_RESP_EN is undefined:
- no error FSM
- Hresp SHALL be tied to 00 and Hreadyerr to 1
- out-of-range transfers SHALL be silently dropped (valid=0)

Structure
REQ-022 Shared package ahb2apb_pkg SHALL hold:
- HTRANS encodings and HRESP codes
- address-map base/limit constants
- the error-state enum typedef
REQ-023 Address decode SHALL be a separate combinational sub-module, ahb_addr_decode, taking Haddr and returning tempselx and an in_range flag.

Verification
REQ-024 Reset: Hreset=1 for 2 cycles with Haddr=0x8000_0010 -> Haddr1=0, Hresp=00, Hreadyerr=1; tempselx=001.
REQ-025 Read pipeline: NONSEQ, Haddr=0x8400_0004, Hwrite=0, Hreadyin=1 -> valid=1 and tempselx=010 same cycle; Haddr1=0x8400_0004 next cycle; Haddr2=0x8400_0004 the cycle after.
REQ-026 Write data alignment: NONSEQ write to 0x8800_0000, then Hwdata=0xDEAD_BEEF in the next cycle -> Hwdata1=0xDEAD_BEEF one cycle later and Hwdata2 one cycle after that; Hwritereg=1.
REQ-027 Stall: Hreadyin=0 for 3 cycles with Haddr changing -> valid=0 and Haddr1/Haddr2/Hwritereg unchanged.
REQ-028 Error (AHB_ERR_RESP_EN): NONSEQ to 0x9000_0000 -> valid=0; next cycle Hresp=01/Hreadyerr=0; then Hresp=01/Hreadyerr=1; then Hresp=00.
REQ-029 Boundary: 0x8BFF_FFFF -> tempselx=100, valid=1; 0x8C00_0000 -> tempselx=000, valid=0. Without the macro, 0x8C00_0000 keeps Hresp=00 throughout.

Source files
------------

// File: rtl/ahb2apb_pkg.sv
// Shared AHB-to-APB bridge definitions: transfer/response codes, the
// peripheral address map and the error-response state type.
package ahb2apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
  localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
  localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
  localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

  typedef enum logic [1:0] {
    ERR_IDLE   = 2'b00,
    ERR_FIRST  = 2'b01,
    ERR_SECOND = 2'b10
  } err_state_e;

  // NONSEQ and SEQ are the only transfer types that carry a real access.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational AHB address decoder: one-hot peripheral select plus an
// in-range flag for the three APB peripheral windows.
module ahb_addr_decode
  import ahb2apb_pkg::*;
(
  input  logic [31:0] haddr,
  output logic [2:0]  tempselx,
  output logic        in_range
);

  always_comb begin
    // NOTE: default first so every path assigns tempselx and no latch is inferred.
    tempselx = 3'b000;
    if (haddr >= SLV0_BASE && haddr <= SLV0_LIMIT) begin
      tempselx = 3'b001;
    end else if (haddr >= SLV1_BASE && haddr <= SLV1_LIMIT) begin
      tempselx = 3'b010;
    end else if (haddr >= SLV2_BASE && haddr <= SLV2_LIMIT) begin
      tempselx = 3'b100;
    end
  end

  assign in_range = |tempselx;

endmodule

// File: rtl/ahb_slave_interface.sv
// AHB slave front end of the AHB-to-APB bridge: address/data pipeline,
// decode and qualification. Define AHB_ERR_RESP_EN to build the two-cycle
// ERROR response for out-of-range transfers; otherwise they are dropped.
module ahb_slave_interface
  import ahb2apb_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyerr
);

  logic        in_range;
  logic        xfer_req;
  logic        err_block;
  logic [31:0] haddr1_d, haddr1_q, haddr2_d, haddr2_q;
  logic [31:0] hwdata1_d, hwdata1_q, hwdata2_d, hwdata2_q;
  logic        hwritereg_d, hwritereg_q;

  ahb_addr_decode u_decode (
    .haddr    (Haddr),
    .tempselx (tempselx),
    .in_range (in_range)
  );

  assign xfer_req = Hreadyin && htrans_active(Htrans);
  assign valid    = xfer_req && in_range && !err_block;
  assign Hrdata   = Prdata;

  // Address and direction stall with HREADY; write data always advances so it
  // lines up one cycle behind its address phase.
  always_comb begin
    haddr1_d    = haddr1_q;
    haddr2_d    = haddr2_q;
    hwritereg_d = hwritereg_q;
    if (Hreadyin) begin
      haddr1_d    = Haddr;
      haddr2_d    = haddr1_q;
      hwritereg_d = Hwrite;
    end
    hwdata1_d = Hwdata;
    hwdata2_d = hwdata1_q;
  end

  always_ff @(posedge Hclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Hreset) begin
      haddr1_q    <= '0;
      haddr2_q    <= '0;
      hwdata1_q   <= '0;
      hwdata2_q   <= '0;
      hwritereg_q <= 1'b0;
    end else begin
      haddr1_q    <= haddr1_d;
      haddr2_q    <= haddr2_d;
      hwdata1_q   <= hwdata1_d;
      hwdata2_q   <= hwdata2_d;
      hwritereg_q <= hwritereg_d;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwritereg_q;

`ifdef AHB_ERR_RESP_EN
  err_state_e state_d, state_q;

  always_comb begin
    state_d   = state_q;
    Hresp     = HRESP_OKAY;
    Hreadyerr = 1'b1;
    unique case (state_q)
      ERR_IDLE: begin
        if (xfer_req && !in_range) state_d = ERR_FIRST;
      end
      ERR_FIRST: begin
        state_d   = ERR_SECOND;
        Hresp     = HRESP_ERROR;
        Hreadyerr = 1'b0;
      end
      ERR_SECOND: begin
        // A new bad access here restarts the response back to back.
        state_d = (xfer_req && !in_range) ? ERR_FIRST : ERR_IDLE;
        Hresp   = HRESP_ERROR;
      end
      default: state_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) state_q <= ERR_IDLE;
    else        state_q <= state_d;
  end

  assign err_block = (state_q == ERR_FIRST);
`else
  assign err_block = 1'b0;
  assign Hresp     = HRESP_OKAY;
  assign Hreadyerr = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed self-checking bench for ahb_slave_interface; error-response
// scenarios are exercised when AHB_ERR_RESP_EN is defined.
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        valid, Hwritereg, Hreadyerr;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int errors = 0;
  int checks = 0;

  ahb_slave_interface dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
    .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .tempselx(tempselx),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyerr(Hreadyerr)
  );

  always #5 Hclk = ~Hclk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1; Hreadyin = 1'b1; Htrans = 2'b10; Hwrite = 1'b1;
    Haddr = 32'h8000_0010; Hwdata = 32'hFFFF_FFFF; Prdata = 32'h1234_5678;
    step(); step(); #1;
    checks++; if (Haddr1 !== 32'h0) begin errors++; $display("FAIL reset_haddr1: got %h want 00000000", Haddr1); end
    checks++; if (Haddr2 !== 32'h0) begin errors++; $display("FAIL reset_haddr2: got %h want 00000000", Haddr2); end
    checks++; if (Hwdata1 !== 32'h0) begin errors++; $display("FAIL reset_hwdata1: got %h want 00000000", Hwdata1); end
    checks++; if (Hwritereg !== 1'b0) begin errors++; $display("FAIL reset_hwritereg: got %b want 0", Hwritereg); end
    checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b want 00", Hresp); end
    checks++; if (Hreadyerr !== 1'b1) begin errors++; $display("FAIL reset_hreadyerr: got %b want 1", Hreadyerr); end
    checks++; if (tempselx !== 3'b001) begin errors++; $display("FAIL reset_tempselx: got %b want 001", tempselx); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL reset_valid: got %b want 1", valid); end
    checks++; if (Hrdata !== 32'h1234_5678) begin errors++; $display("FAIL reset_hrdata: got %h want 12345678", Hrdata); end
    Hreset = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'h0;
    step();
  endtask

  task automatic test_read_pipeline();
    Htrans = 2'b10; Haddr = 32'h8400_0004; Hwrite = 1'b0; Hreadyin = 1'b1;
    Prdata = 32'hA5A5_0F0F;
    #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b want 1", valid); end
    checks++; if (tempselx !== 3'b010) begin errors++; $display("FAIL read_tempselx: got %b want 010", tempselx); end
    checks++; if (Hrdata !== 32'hA5A5_0F0F) begin errors++; $display("FAIL read_hrdata: got %h want a5a50f0f", Hrdata); end
    step();
    checks++; if (Haddr1 !== 32'h8400_0004) begin errors++; $display("FAIL read_haddr1: got %h want 84000004", Haddr1); end
    Htrans = 2'b00; Haddr = 32'h0;
    step();
    checks++; if (Haddr2 !== 32'h8400_0004) begin errors++; $display("FAIL read_haddr2: got %h want 84000004", Haddr2); end
    checks++; if (Haddr1 !== 32'h0) begin errors++; $display("FAIL read_haddr1_next: got %h want 00000000", Haddr1); end
  endtask

  task automatic test_write_alignment();
    Htrans = 2'b10; Haddr = 32'h8800_0000; Hwrite = 1'b1; Hreadyin = 1'b1; Hwdata = 32'h0;
    #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL write_valid: got %b want 1", valid); end
    checks++; if (tempselx !== 3'b100) begin errors++; $display("FAIL write_tempselx: got %b want 100", tempselx); end
    step();
    checks++; if (Hwritereg !== 1'b1) begin errors++; $display("FAIL write_hwritereg: got %b want 1", Hwritereg); end
    checks++; if (Haddr1 !== 32'h8800_0000) begin errors++; $display("FAIL write_haddr1: got %h want 88000000", Haddr1); end
    Htrans = 2'b00; Hwrite = 1'b0; Haddr = 32'h0; Hwdata = 32'hDEAD_BEEF;
    step();
    checks++; if (Hwdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_hwdata1: got %h want deadbeef", Hwdata1); end
    Hwdata = 32'h0;
    step();
    checks++; if (Hwdata2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_hwdata2: got %h want deadbeef", Hwdata2); end
    checks++; if (Hwdata1 !== 32'h0) begin errors++; $display("FAIL write_hwdata1_next: got %h want 00000000", Hwdata1); end
  endtask

  task automatic test_stall();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8000_0100; Hwrite = 1'b0;
    step();
    Haddr = 32'h8000_0200; Hwrite = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      Hreadyin = 1'b0; Htrans = 2'b10; Hwrite = 1'b0;
      Haddr = 32'h8400_0000 + 32'(i * 16); Hwdata = 32'h5000_0000 + 32'(i);
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 0", i, valid); end
      step();
      checks++; if (Haddr1 !== 32'h8000_0200) begin errors++; $display("FAIL stall_haddr1[%0d]: got %h want 80000200", i, Haddr1); end
      checks++; if (Haddr2 !== 32'h8000_0100) begin errors++; $display("FAIL stall_haddr2[%0d]: got %h want 80000100", i, Haddr2); end
      checks++; if (Hwritereg !== 1'b1) begin errors++; $display("FAIL stall_hwritereg[%0d]: got %b want 1", i, Hwritereg); end
      checks++; if (Hwdata1 !== 32'h5000_0000 + 32'(i)) begin errors++; $display("FAIL stall_hwdata1[%0d]: got %h want %h", i, Hwdata1, 32'h5000_0000 + 32'(i)); end
    end
    Hreadyin = 1'b1; Htrans = 2'b00; Haddr = 32'h0; Hwdata = 32'h0;
    step();
  endtask

  task automatic test_trans_types();
    logic [1:0]  tr_tab [4] = '{2'b01, 2'b00, 2'b11, 2'b01};
    logic [31:0] ad_tab [4] = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0040, 32'h9000_0000};
    logic        vl_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      Hreadyin = 1'b1; Htrans = tr_tab[i]; Haddr = ad_tab[i];
      #1;
      checks++; if (valid !== vl_tab[i]) begin errors++; $display("FAIL trans_valid[%0d]: got %b want %b", i, valid, vl_tab[i]); end
      step();
      checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL trans_hresp[%0d]: got %b want 00", i, Hresp); end
    end
    Htrans = 2'b00; Haddr = 32'h0;
    step();
  endtask

  task automatic test_boundary();
    logic [31:0] ad_tab [7] = '{32'h7FFF_FFFF, 32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFF,
                                32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
    logic [2:0]  sel_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
    Hreadyin = 1'b1; Htrans = 2'b00;
    for (int i = 0; i < 7; i++) begin
      Haddr = ad_tab[i];
      #1;
      checks++; if (tempselx !== sel_tab[i]) begin errors++; $display("FAIL boundary_sel[%0d]: got %b want %b", i, tempselx, sel_tab[i]); end
    end
    Htrans = 2'b10; Haddr = 32'h8BFF_FFFF;
    #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL boundary_valid_top: got %b want 1", valid); end
    Htrans = 2'b00;
    step();
`ifndef AHB_ERR_RESP_EN
    Htrans = 2'b10; Haddr = 32'h8C00_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL boundary_valid_out[%0d]: got %b want 0", i, valid); end
      checks++; if (Hresp !== 2'b00 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL boundary_resp[%0d]: got %b/%b want 00/1", i, Hresp, Hreadyerr); end
      step();
    end
    Htrans = 2'b00; Haddr = 32'h0;
    step();
`endif
  endtask

`ifdef AHB_ERR_RESP_EN
  task automatic test_error();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h9000_0000;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL err_valid: got %b want 0", valid); end
    checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL err_idle_resp: got %b want 00", Hresp); end
    step();
    checks++; if (Hresp !== 2'b01 || Hreadyerr !== 1'b0) begin errors++; $display("FAIL err_first: got %b/%b want 01/0", Hresp, Hreadyerr); end
    Htrans = 2'b10; Haddr = 32'h8000_0000;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL err_first_valid: got %b want 0", valid); end
    step();
    checks++; if (Hresp !== 2'b01 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL err_second: got %b/%b want 01/1", Hresp, Hreadyerr); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL err_second_valid: got %b want 1", valid); end
    Htrans = 2'b00;
    step();
    checks++; if (Hresp !== 2'b00 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL err_done: got %b/%b want 00/1", Hresp, Hreadyerr); end
  endtask

  task automatic test_back_to_back();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8C00_0000;
    step();
    Htrans = 2'b00;
    step();
    checks++; if (Hresp !== 2'b01 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b/%b want 01/1", Hresp, Hreadyerr); end
    Htrans = 2'b11; Haddr = 32'hFFFF_0000;
    step();
    checks++; if (Hresp !== 2'b01 || Hreadyerr !== 1'b0) begin errors++; $display("FAIL b2b_refirst: got %b/%b want 01/0", Hresp, Hreadyerr); end
    Htrans = 2'b00;
    step(); step();
    checks++; if (Hresp !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b want 00", Hresp); end
  endtask

  task automatic test_reset_abort();
    Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h9000_0000;
    step();
    Htrans = 2'b00; Hreset = 1'b1;
    step();
    checks++; if (Hresp !== 2'b00 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL abort_reset: got %b/%b want 00/1", Hresp, Hreadyerr); end
    Hreset = 1'b0;
    step();
    checks++; if (Hresp !== 2'b00 || Hreadyerr !== 1'b1) begin errors++; $display("FAIL abort_after: got %b/%b want 00/1", Hresp, Hreadyerr); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_pipeline();
    test_write_alignment();
    test_stall();
    test_trans_types();
    test_boundary();
`ifdef AHB_ERR_RESP_EN
    test_error();
    test_back_to_back();
    test_reset_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
